// File: rtl/burst_read_freezer.sv
// burst_read_freezer
//
// Bridges a fast memory read port to a slow consumer that only advances on
// io_tick. One memory request is issued per burst and duplicates are held
// off while that burst is outstanding. Returned words are queued in a small
// FIFO and handed to the consumer one per tick period. Each word is held
// stable until the next tick.
//
// Ports
//   clock, reset      clock and asynchronous active-low reset
//   io_tick           one-cycle pulse at each consumer period boundary
//   io_in_rd/addr     consumer read request and address
//   io_in_dout/valid  presented word, registered, held for a whole period
//   io_in_wait_n      consumer-side acceptance, frozen until the next tick
//   io_out_rd/addr    memory read request and address
//   io_out_dout/valid memory return data
//   io_out_wait_n     memory accepts the request
//   io_pending        a burst is outstanding
//   io_level          FIFO occupancy
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no burst outstanding; io_in_rd is forwarded to memory
// S_BUSY  | burst accepted; requests suppressed until its last word pops
module burst_read_freezer #(
   parameter int ADDR_WIDTH   = 25,
   parameter int DATA_WIDTH   = 8,
   parameter int BURST_LENGTH = 1,
   parameter int DEPTH        = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         io_tick,
   input  logic                         io_in_rd,
   input  logic [ADDR_WIDTH-1:0]        io_in_addr,
   output logic [DATA_WIDTH-1:0]        io_in_dout,
   output logic                         io_in_wait_n,
   output logic                         io_in_valid,
   output logic                         io_out_rd,
   output logic [ADDR_WIDTH-1:0]        io_out_addr,
   input  logic [DATA_WIDTH-1:0]        io_out_dout,
   input  logic                         io_out_wait_n,
   input  logic                         io_out_valid,
   output logic                         io_pending,
   output logic [$clog2(DEPTH+1)-1:0]   io_level
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int CNT_W = $clog2(BURST_LENGTH + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       rx_count, tx_count;
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [LVL_W-1:0]       level;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [DATA_WIDTH-1:0]  pres_reg;
   logic                   pres_valid;
   logic                   wait_hold;

   logic pending, accept, push, pop, last_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign pending  = (state_q == S_BUSY);
   assign accept   = io_out_rd & io_out_wait_n;
   // Data arriving with no burst words left to receive is stale and dropped.
   assign push     = io_out_valid & (rx_count != '0);
   // The pop looks at the registered level only, so a word pushed this cycle
   // is never presented by a coincident tick.
   assign pop      = io_tick & (level != '0);
   assign last_pop = pop & (tx_count == CNT_W'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      io_out_rd = 1'b0;
      case (state_q)
         S_IDLE: begin
            io_out_rd = io_in_rd;
            if (io_in_rd && io_out_wait_n) state_d = S_BUSY;
         end
         S_BUSY: begin
            if (last_pop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // tx_count is also loaded on accept so the first burst after reset
   // counts correctly even though reset clears it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_count <= '0;
         tx_count <= '0;
      end else begin
         if (accept)    rx_count <= CNT_W'(BURST_LENGTH);
         else if (push) rx_count <= rx_count - CNT_W'(1);

         if (accept || last_pop) tx_count <= CNT_W'(BURST_LENGTH);
         else if (pop)           tx_count <= tx_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= io_out_dout;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pres_reg   <= '0;
         pres_valid <= 1'b0;
      end else if (pop) begin
         pres_reg   <= mem[rd_ptr];
         pres_valid <= 1'b1;
      end else if (io_tick) begin
         pres_valid <= 1'b0;
      end
   end

   // Accept wins over a coincident tick so the consumer sees the acceptance
   // for the whole following period.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       wait_hold <= 1'b0;
      else if (accept)  wait_hold <= 1'b1;
      else if (io_tick) wait_hold <= 1'b0;
   end

   assign io_in_wait_n = wait_hold | (io_out_wait_n & ~pending);
   assign io_out_addr  = io_in_addr;
   assign io_in_dout   = pres_reg;
   assign io_in_valid  = pres_valid;
   assign io_pending   = pending;
   assign io_level     = level;

endmodule

// File: tb/tb_burst_read_freezer.sv
module tb_burst_read_freezer;

   localparam int AW    = 25;
   localparam int DW    = 8;
   localparam int BL    = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          io_tick = 1'b0;
   logic          io_in_rd = 1'b0;
   logic [AW-1:0] io_in_addr = '0;
   logic [DW-1:0] io_in_dout;
   logic          io_in_wait_n;
   logic          io_in_valid;
   logic          io_out_rd;
   logic [AW-1:0] io_out_addr;
   logic [DW-1:0] io_out_dout = '0;
   logic          io_out_wait_n = 1'b0;
   logic          io_out_valid = 1'b0;
   logic          io_pending;
   logic [LW-1:0] io_level;

   always #5 clock = ~clock;

   burst_read_freezer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL), .DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .io_tick(io_tick),
      .io_in_rd(io_in_rd), .io_in_addr(io_in_addr),
      .io_in_dout(io_in_dout), .io_in_wait_n(io_in_wait_n),
      .io_in_valid(io_in_valid), .io_out_rd(io_out_rd),
      .io_out_addr(io_out_addr), .io_out_dout(io_out_dout),
      .io_out_wait_n(io_out_wait_n), .io_out_valid(io_out_valid),
      .io_pending(io_pending), .io_level(io_level)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Expected presentation at each tick, consumed by the monitor.
   typedef struct {
      logic          v;
      logic [DW-1:0] d;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: burst bookkeeping as plain counts plus a word queue.
   bit            m_pend, m_hold, m_pv;
   int            m_rx, m_tx;
   logic [DW-1:0] m_pd;
   logic [DW-1:0] m_fifo[$];

   task automatic model_reset();
      m_pend = 0; m_hold = 0; m_pv = 0;
      m_rx = 0; m_tx = 0; m_pd = '0;
      m_fifo.delete();
   endtask

   task automatic model_step();
      bit accept;
      exp_t e;
      accept = io_in_rd && !m_pend && io_out_wait_n;
      if (io_tick) begin
         if (m_fifo.size() > 0) begin
            m_pd = m_fifo.pop_front();
            m_pv = 1;
            m_tx = m_tx - 1;
            if (m_tx == 0) begin
               m_pend = 0;
               m_tx   = BL;
            end
         end else begin
            m_pv = 0;
         end
         e.v = m_pv;
         e.d = m_pd;
         exp_q.push_back(e);
      end
      if (io_out_valid && m_rx > 0) begin
         m_fifo.push_back(io_out_dout);
         m_rx = m_rx - 1;
      end
      if (accept) begin
         m_pend = 1;
         m_rx   = BL;
         m_tx   = BL;
         m_hold = 1;
      end else if (io_tick) begin
         m_hold = 0;
      end
   endtask

   // Monitor: at every tick edge the DUT presents a new period; compare it.
   initial begin
      bit t;
      exp_t e;
      forever begin
         @(posedge clock);
         t = io_tick;
         #1;
         if (reset === 1'b1 && t) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_valid", io_in_valid, e.v);
               chk("sb_dout", io_in_dout, e.d);
            end
         end
      end
   end

   task automatic cyc(input bit t, input bit rd, input logic [AW-1:0] a,
                      input bit ow, input bit ov, input logic [DW-1:0] od);
      @(negedge clock);
      chk("level", io_level, m_fifo.size());
      chk("pending", io_pending, m_pend);
      chk("in_valid", io_in_valid, m_pv);
      chk("in_dout", io_in_dout, m_pd);
      io_tick = t; io_in_rd = rd; io_in_addr = a;
      io_out_wait_n = ow; io_out_valid = ov; io_out_dout = od;
      #1;
      chk("out_rd", io_out_rd, rd & ~m_pend);
      chk("out_addr", io_out_addr, a);
      chk("in_wait_n", io_in_wait_n, m_hold | (ow & ~m_pend));
      @(posedge clock);
      model_step();
   endtask

   task automatic check_reset_outputs();
      chk("rst_dout", io_in_dout, 0);
      chk("rst_valid", io_in_valid, 0);
      chk("rst_wait_n", io_in_wait_n, 0);
      chk("rst_pending", io_pending, 0);
      chk("rst_level", io_level, 0);
      chk("rst_out_rd", io_out_rd, 1);
   endtask

   task automatic do_reset();
      #3;
      io_in_rd = 1; io_out_wait_n = 0; io_tick = 0; io_out_valid = 0;
      reset = 0;
      #1;
      check_reset_outputs();
      model_reset();
      exp_q.delete();
      io_in_rd = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1;
   endtask

   task automatic run_random(input int ncyc, input int per, input int p_rd,
                             input int p_ow, input int p_ov);
      for (int i = 0; i < ncyc; i++)
         cyc((i % per) == per - 1, $urandom_range(99) < p_rd, AW'($urandom),
             $urandom_range(99) < p_ow, $urandom_range(99) < p_ov, DW'($urandom));
   endtask

   initial begin
      logic [DW-1:0] words [4];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
      model_reset();
      io_in_rd = 1;
      #12;
      check_reset_outputs();
      io_in_rd = 0;
      @(negedge clock);
      reset = 1;

      // Back-to-back burst with the consumer holding its request.
      cyc(0, 1, 25'h100, 1, 0, 8'h00);
      for (int i = 0; i < 4; i++) cyc(0, 1, 25'h100, 1, 1, words[i]);
      for (int i = 0; i < 20; i++) cyc((i % 4) == 3, i < 8, 25'h100, 1, 0, 8'h00);

      // Reset after two of four words, then the stragglers must be dropped.
      cyc(0, 1, 25'h200, 1, 0, 8'h00);
      cyc(0, 0, 25'h200, 1, 1, 8'h55);
      cyc(0, 0, 25'h200, 1, 1, 8'h66);
      do_reset();
      cyc(0, 0, 25'h200, 1, 1, 8'h77);
      cyc(0, 0, 25'h200, 1, 1, 8'h88);
      for (int i = 0; i < 8; i++) cyc((i % 4) == 3, 0, 25'h0, 1, 0, 8'h00);

      run_random(400, 4, 70, 70, 50);
      run_random(400, 1, 60, 50, 30);
      run_random(400, 3, 80, 40, 90);
      run_random(400, 5, 50, 80, 20);
      cyc(0, 1, 25'h300, 1, 0, 8'h00);
      cyc(0, 1, 25'h300, 1, 1, 8'h9c);
      do_reset();
      run_random(400, 2, 70, 60, 60);

      #2;
      chk("sb_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
